// File: rtl/caption_pkg.sv
// caption_pkg: shared constants and types for the caption word-wrapper.
package caption_pkg;

  localparam int unsigned CAPTION_MAX_CHARS      = 32;
  localparam int unsigned CAPTION_CHARS_PER_LINE = 18;
  localparam int unsigned CAPTION_MAX_LINES      = 2;
  localparam int unsigned CAPTION_HOLD_W         = 10;

  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_LF    = 8'h0A;
  localparam logic [7:0] ASCII_DOT   = 8'h2E;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StScan,
    StEmit,
    StHold
  } caption_state_t;

  // Packed line: char c lives at bits [255-8c -: 8].
  typedef logic [255:0] caption_line_t;

  localparam caption_line_t CAPTION_BLANK_LINE = {32{ASCII_SPACE}};

endpackage

// File: rtl/caption_wrapper_if.sv
// caption_wrapper_if: byte-stream input and packed-line output of the wrapper.
interface caption_wrapper_if;
  import caption_pkg::*;

  logic          in_valid;
  logic          in_ready;
  logic [7:0]    in_data;
  logic          in_last;
  logic          text_valid;
  logic          text_line;
  caption_line_t text_string;
  logic [4:0]    text_length;

  // Producer of bytes / consumer of lines.
  modport master (
    output in_valid, in_data, in_last,
    input  in_ready,
    input  text_valid, text_line, text_string, text_length
  );

  // The wrapper itself.
  modport slave (
    input  in_valid, in_data, in_last,
    output in_ready,
    output text_valid, text_line, text_string, text_length
  );

endinterface

// File: rtl/caption_msg_buffer.sv
// caption_msg_buffer: message byte store with write port, fill count and a
// combinational read at the scan index (reads past the count return a space).
module caption_msg_buffer
  import caption_pkg::*;
#(
  parameter int unsigned MAX_CHARS = CAPTION_MAX_CHARS
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_first,
  input  logic                       i_wr_en,
  input  logic [7:0]                 i_wr_data,
  input  logic [$clog2(MAX_CHARS):0] i_rd_idx,
  output logic [7:0]                 o_rd_data,
  output logic [$clog2(MAX_CHARS):0] o_count,
  output logic                       o_full
);
  localparam int unsigned CW = $clog2(MAX_CHARS) + 1;
  localparam logic [CW-1:0] MaxCount = CW'(MAX_CHARS);

  logic [7:0]    r_mem [MAX_CHARS];
  logic [CW-1:0] r_count;
  logic [CW-2:0] w_wr_idx;
  logic          w_wr;

  assign w_wr     = i_wr_first || (i_wr_en && !o_full);
  assign w_wr_idx = i_wr_first ? '0 : r_count[CW-2:0];
  assign o_count  = r_count;
  assign o_full   = (r_count == MaxCount);
  assign o_rd_data = (i_rd_idx < r_count) ? r_mem[i_rd_idx[CW-2:0]] : ASCII_SPACE;

  // Byte storage; contents beyond the count are never read.
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[w_wr_idx] <= i_wr_data;
  end

  // Fill count: first byte restarts the message, later bytes append.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_wr_first) begin
      r_count <= CW'(1);
    end else if (i_wr_en && !o_full) begin
      r_count <= r_count + CW'(1);
    end
  end

endmodule

// File: rtl/caption_wrapper.sv
// caption_wrapper: buffers a byte-stream message, word-wraps it into at most
// MAX_LINES lines of CHARS_PER_LINE chars, pulses each line out, then holds
// the caption for cfg_hold_frames vblanks before pulsing caption_clear.
// Build option CAPTION_WRAPPER_ELLIPSIS_EN: a truncated message gets "..."
// on its last emitted line.
module caption_wrapper
  import caption_pkg::*;
#(
  parameter int unsigned MAX_CHARS      = CAPTION_MAX_CHARS,
  parameter int unsigned CHARS_PER_LINE = CAPTION_CHARS_PER_LINE,
  parameter int unsigned MAX_LINES      = CAPTION_MAX_LINES,
  parameter int unsigned HOLD_W         = CAPTION_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  caption_wrapper_if.slave  bus,
  input  logic              vblank_pulse,
  input  logic [HOLD_W-1:0] cfg_hold_frames,
  output logic              caption_clear,
  output logic              busy
);
  localparam int unsigned CW = $clog2(MAX_CHARS) + 1;
  localparam int unsigned TW = 5;  // matches text_length
  localparam int unsigned LW = (MAX_LINES > 1) ? $clog2(MAX_LINES) : 1;
  localparam logic [TW-1:0] CplLen = TW'(CHARS_PER_LINE);

`ifdef CAPTION_WRAPPER_ELLIPSIS_EN
  localparam bit EllipsisEn = 1'b1;
`else
  localparam bit EllipsisEn = 1'b0;
`endif

  caption_state_t    r_state;
  logic [CW-1:0]     r_pos, r_start, r_last_space, r_next;
  logic              r_ls_valid, r_skipping, r_more, r_trunc, r_dropped;
  logic [TW-1:0]     r_taken, r_len;
  logic [LW-1:0]     r_line;
  logic [HOLD_W-1:0] r_hold;
  logic [7:0]        r_chars [CHARS_PER_LINE];
  logic              r_text_valid, r_text_line, r_clear;
  caption_line_t     r_text_string;
  logic [TW-1:0]     r_text_length;

  logic          w_xfer, w_wr_first, w_wr_en, w_full;
  logic [7:0]    w_rd_data;
  logic [CW-1:0] w_count, w_next;
  logic          w_at_end, w_term, w_skip, w_remain, w_more, w_trunc;
  logic [TW-1:0] w_len, w_keep, w_out_len;
  caption_line_t w_line;

  assign bus.in_ready    = (r_state == StIdle) || (r_state == StLoad) || (r_state == StHold);
  assign busy            = (r_state == StScan) || (r_state == StEmit);
  assign bus.text_valid  = r_text_valid;
  assign bus.text_line   = r_text_line;
  assign bus.text_string = r_text_string;
  assign bus.text_length = r_text_length;
  assign caption_clear   = r_clear;

  assign w_xfer     = bus.in_valid && bus.in_ready;
  assign w_wr_first = w_xfer && ((r_state == StIdle) || (r_state == StHold));
  assign w_wr_en    = w_xfer && (r_state == StLoad);

  caption_msg_buffer #(
    .MAX_CHARS(MAX_CHARS)
  ) u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_wr_first(w_wr_first),
    .i_wr_en   (w_wr_en),
    .i_wr_data (bus.in_data),
    .i_rd_idx  (r_pos),
    .o_rd_data (w_rd_data),
    .o_count   (w_count),
    .o_full    (w_full)
  );

  assign w_at_end = (r_pos >= w_count);
  assign w_remain = (w_next < w_count);
  assign w_more   = w_remain && ((int'(r_line) + 1) < int'(MAX_LINES));
  assign w_trunc  = !w_more && (w_remain || r_dropped);

  // Line-termination decision for the byte currently under the scan index.
  always_comb begin
    w_term = 1'b0;
    w_skip = 1'b0;
    w_len  = r_taken;
    w_next = r_pos;
    if (w_at_end) begin
      w_term = 1'b1;
    end else if (w_rd_data == ASCII_LF) begin
      w_term = 1'b1;
      w_next = r_pos + CW'(1);
    end else if (r_skipping && (w_rd_data == ASCII_SPACE)) begin
      w_skip = 1'b1;
    end else if (r_taken == CplLen) begin
      w_term = 1'b1;
      if (w_rd_data == ASCII_SPACE) begin
        w_next = r_pos + CW'(1);
      end else if (r_ls_valid) begin
        w_len  = TW'(r_last_space - r_start);
        w_next = r_last_space + CW'(1);
      end
    end
  end

  // Packed output line: kept chars, optional dots, space padding.
  always_comb begin
    w_keep = r_len;
    if (EllipsisEn && r_trunc && (r_len > CplLen - TW'(3))) w_keep = CplLen - TW'(3);
    w_out_len = (EllipsisEn && r_trunc) ? (w_keep + TW'(3)) : r_len;
    w_line = CAPTION_BLANK_LINE;
    for (int c = 0; c < int'(CHARS_PER_LINE); c++) begin
      if (TW'(c) < w_keep) begin
        w_line[255-8*c -: 8] = r_chars[c];
      end else if (EllipsisEn && r_trunc && (TW'(c) < w_keep + TW'(3))) begin
        w_line[255-8*c -: 8] = ASCII_DOT;
      end
    end
  end

  // Main FSM: load, scan, emit and hold, with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= StIdle;
      r_pos         <= '0;
      r_start       <= '0;
      r_last_space  <= '0;
      r_next        <= '0;
      r_ls_valid    <= 1'b0;
      r_skipping    <= 1'b1;
      r_more        <= 1'b0;
      r_trunc       <= 1'b0;
      r_dropped     <= 1'b0;
      r_taken       <= '0;
      r_len         <= '0;
      r_line        <= '0;
      r_hold        <= '0;
      for (int i = 0; i < int'(CHARS_PER_LINE); i++) r_chars[i] <= ASCII_SPACE;
      r_text_valid  <= 1'b0;
      r_text_line   <= 1'b0;
      r_text_string <= CAPTION_BLANK_LINE;
      r_text_length <= '0;
      r_clear       <= 1'b0;
    end else begin
      r_text_valid <= 1'b0;
      r_clear      <= 1'b0;
      unique case (r_state)
        StIdle, StHold: begin
          if (w_xfer) begin
            // New message start; also cancels any running hold.
            r_dropped <= 1'b0;
            r_state   <= bus.in_last ? StScan : StLoad;
            r_pos     <= '0;
            r_line    <= '0;
            r_taken   <= '0;
            r_skipping <= 1'b1;
            r_ls_valid <= 1'b0;
          end else if ((r_state == StHold) && vblank_pulse && (r_hold != '0)) begin
            r_hold <= r_hold - HOLD_W'(1);
            if (r_hold == HOLD_W'(1)) begin
              r_clear <= 1'b1;
              r_state <= StIdle;
            end
          end
        end
        StLoad: begin
          if (w_xfer) begin
            if (w_full) r_dropped <= 1'b1;
            if (bus.in_last) r_state <= StScan;
          end
        end
        StScan: begin
          if (w_term) begin
            r_len   <= w_len;
            r_next  <= w_next;
            r_more  <= w_more;
            r_trunc <= w_trunc;
            r_state <= StEmit;
          end else if (w_skip) begin
            r_pos <= r_pos + CW'(1);
          end else begin
            if (r_skipping) begin
              r_start    <= r_pos;
              r_skipping <= 1'b0;
            end
            if (w_rd_data == ASCII_SPACE) begin
              r_last_space <= r_pos;
              r_ls_valid   <= 1'b1;
            end
            r_chars[r_taken] <= w_rd_data;
            r_taken <= r_taken + TW'(1);
            r_pos   <= r_pos + CW'(1);
          end
        end
        StEmit: begin
          r_text_valid  <= 1'b1;
          r_text_line   <= r_line[0];
          r_text_string <= w_line;
          r_text_length <= w_out_len;
          if (r_more) begin
            r_state    <= StScan;
            r_pos      <= r_next;
            r_line     <= r_line + LW'(1);
            r_taken    <= '0;
            r_skipping <= 1'b1;
            r_ls_valid <= 1'b0;
          end else begin
            r_state <= StHold;
            r_hold  <= cfg_hold_frames;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule
